// File: rtl/ahb_sram_subordinate.sv
// AHB-lite subordinate backed by a word-organised SRAM, with programmable OKAY wait states
// and the two-cycle ERROR response. Sub-word read data is replicated across byte lanes.
module ahb_sram_subordinate #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [1:0]            i_htrans,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [IdxW+1:0] addr_q, addr_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;

  logic                  accept, addr_err, mem_we;
  logic [IdxW-1:0]       idx;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign accept = i_hsel & i_hready & i_htrans[1];

  always_comb begin
    addr_err = 1'b0;
    if (i_hsize > 3'b010) addr_err = 1'b1;
    if (i_hsize == 3'b001 && i_haddr[0]) addr_err = 1'b1;
    if (i_hsize == 3'b010 && i_haddr[1:0] != 2'b00) addr_err = 1'b1;
    if (|i_haddr[ADDR_WIDTH-1:IdxW+2]) addr_err = 1'b1;
  end

  always_comb begin
    o_hreadyout = 1'b1;
    o_hresp     = 1'b0;
    case (state_q)
      S_DATA:  o_hreadyout = (wcnt_q == 3'd0);
      S_ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = 1'b1;
      end
      S_ERR2:  o_hresp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (o_hreadyout) begin
      if (accept) begin
        addr_d  = i_haddr[IdxW+1:0];
        write_d = i_hwrite;
        size_d  = i_hsize[1:0];
        state_d = addr_err ? S_ERR1 : S_DATA;
        wcnt_d  = addr_err ? 3'd0 : 3'(WAIT_STATES);
      end else begin
        state_d = S_IDLE;
        wcnt_d  = 3'd0;
      end
    end else begin
      // Only an S_DATA wait cycle lands here.
      wcnt_d = wcnt_q - 3'd1;
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  assign idx    = addr_q[IdxW+1:2];
  assign mem_we = (state_q == S_DATA) & o_hreadyout & write_q;

  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_hclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= i_hwdata[8*i +: 8];
      end
    end
  end

  assign word = mem[idx];

  always_comb begin
    o_hrdata = '0;
    if (state_q == S_DATA && !write_q) begin
      case (size_q)
        2'b00:   o_hrdata = {4{word[{addr_q[1:0], 3'b000} +: 8]}};
        2'b01:   o_hrdata = addr_q[1] ? {2{word[31:16]}} : {2{word[15:0]}};
        default: o_hrdata = word;
      endcase
    end
  end

endmodule
